// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequences clear, operand feed/skew flush and result drain for one DIMxDIM systolic multiply
module matmul_seq_ctrl #(
    parameter int DIM         = 4,
    parameter int SP_NTARGETS = 4,
    parameter int TGT_W       = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    parameter int IDX_W       = (DIM > 1) ? $clog2(DIM) : 1,
    parameter int CNT_W       = $clog2(3*DIM-1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [TGT_W-1:0] sp_target_i,
    input  logic             abort_i,
    output logic             op_rd_en_o,
    output logic [IDX_W-1:0] op_rd_idx_o,
    output logic             pe_clr_o,
    output logic             pe_en_o,
    output logic             res_we_o,
    output logic [IDX_W-1:0] res_row_o,
    output logic [TGT_W-1:0] res_tgt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, WRITE, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] row;
    logic [TGT_W-1:0] tgt;
    logic             err;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
            tgt   <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (start_i && 32'(sp_target_i) < SP_NTARGETS) begin
                    tgt   <= sp_target_i;
                    state <= CLEAR;
                end else if (start_i) begin
                    err <= 1'b1;
                end
            end else if (abort_i) begin
                state <= IDLE;
                cnt   <= '0;
                row   <= '0;
            end else begin
                case (state)
                    CLEAR: state <= COMPUTE;
                    COMPUTE: begin
                        if (cnt == CNT_W'(3*DIM-3)) begin
                            state <= WRITE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WRITE: begin
                        if (row == IDX_W'(DIM-1)) begin
                            state <= DONE;
                            row   <= '0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign pe_clr_o    = state == CLEAR;
    assign pe_en_o     = state == COMPUTE;
    assign op_rd_en_o  = state == COMPUTE && 32'(cnt) < DIM;
    assign op_rd_idx_o = op_rd_en_o ? cnt[IDX_W-1:0] : '0;
    assign res_we_o    = state == WRITE;
    assign res_row_o   = row;
    assign res_tgt_o   = tgt;
    assign busy_o      = state != IDLE;
    assign done_o      = state == DONE;
    assign err_o       = err;
endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Control FSM that sequences one matrix-multiply operation on the DIM×DIM systolic PE array inside matmul.
- Launched by a start pulse from the APB register file. Clears the PE accumulators, then streams operand rows from operand memory for the required number of feed-and-skew cycles.
- Drains the DIM result rows into the selected scratchpad target, then reports done.
- Drives the module-level busy_o.

Parameters:
- DIM, 4, systolic array dimension; operands are DIM×DIM.
- SP_NTARGETS, 4, number of scratchpad targets selectable for the result.
- TGT_W, $clog2(SP_NTARGETS) (min 1), width of the target select.
- IDX_W, $clog2(DIM) (min 1), width of the row and operand index.
- CNT_W, $clog2(3*DIM-1), width of the compute counter.

Ports:
- clk_i  in  1  system clock; all state updates on posedge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse from the register file
- sp_target_i  in  TGT_W  result scratchpad target, sampled with start_i
- abort_i  in  1  synchronous abort request
- op_rd_en_o  out  1  operand memory read enable (A row and B column)
- op_rd_idx_o  out  IDX_W  operand row/column index
- pe_clr_o  out  1  clear all PE accumulators
- pe_en_o  out  1  PE array shift/MAC enable
- res_we_o  out  1  result row write enable to scratchpad
- res_row_o  out  IDX_W  result row index being written
- res_tgt_o  out  TGT_W  latched scratchpad target
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse: start rejected (bad target)

Behaviour:
- Reset: state=IDLE, all counters and latched target cleared to 0.
  - Reset is asynchronous and takes effect immediately, including mid-operation.
  - Every output is 0 while rst_ni=0 and in the first cycle after release.
- All outputs are decoded from registered state/counters only; there is no combinational path from any input to any output.
- States: IDLE, CLEAR, COMPUTE, WRITE, DONE.
- IDLE:
  - Accept condition: start_i=1 and sp_target_i<SP_NTARGETS. Latch target into res_tgt_o, go to CLEAR.
  - Reject condition: start_i=1 and sp_target_i>=SP_NTARGETS. err_o=1 next cycle, state stays IDLE, nothing latched.
- CLEAR:
  - Exactly 1 cycle; pe_clr_o=1.
  - Go to COMPUTE with cnt=0.
- COMPUTE:
  - Lasts 3*DIM-2 cycles (cnt 0..3*DIM-3); pe_en_o=1 throughout.
  - op_rd_en_o=1 and op_rd_idx_o=cnt only while cnt<DIM; otherwise op_rd_en_o=0 and op_rd_idx_o=0.
  - The remaining 2*(DIM-1) cycles flush the array skew.
  - At cnt=3*DIM-3 go to WRITE with row=0.
- WRITE:
  - Lasts DIM cycles; res_we_o=1, res_row_o=row (0..DIM-1), pe_en_o=0.
  - After row=DIM-1 go to DONE.
- DONE:
  - 1 cycle; done_o=1.
  - Go to IDLE.
- busy_o=1 in CLEAR, COMPUTE, WRITE and DONE; 0 in IDLE.
- Busy window is 4*DIM cycles, which is 16 for DIM=4.
- Latency: if start_i is sampled at edge t, done_o is high during cycle t+4*DIM.
- start_i while busy_o=1, including in DONE: ignored, with no err_o and no effect on the target latch.
- abort_i=1 in any non-IDLE state:
  - Next state is IDLE; counters are cleared; no done_o.
  - Any PE or write strobe stops after the current cycle.
- abort_i has priority over all state transitions, including DONE→IDLE; it has no effect in IDLE.
- abort_i and start_i in the same IDLE cycle: start is processed normally.
- Counters never wrap: cnt saturates at its terminal value and row stops at DIM-1, because the state exits first.
- res_tgt_o holds its value after DONE until the next accepted start.

Test Plan:
- DIM=4, start_i pulse with sp_target_i=2:
  - pe_clr_o for 1 cycle.
  - pe_en_o for 10 cycles, with op_rd_en_o only on the first 4 and op_rd_idx_o=0,1,2,3.
  - res_we_o for 4 cycles, with res_row_o=0..3 and res_tgt_o=2.
  - done_o 16 cycles after the start edge; busy_o high for exactly 16 cycles.
- Second start_i during COMPUTE with sp_target_i=1 -> ignored; res_tgt_o stays 2, timing identical to the first scenario, no err_o.
- SP_NTARGETS=3, start_i with sp_target_i=3 -> err_o single pulse, busy_o stays 0, no pe_clr_o.
- abort_i on the 5th COMPUTE cycle -> next cycle IDLE, pe_en_o=0 and busy_o=0, no res_we_o, no done_o; a fresh start then completes in the full 16 cycles.
- rst_ni driven low asynchronously mid-WRITE (row=2) -> all outputs 0 immediately without a clock edge; after release, state is IDLE and busy_o=0.
- Back-to-back: start_i on the first IDLE cycle after done_o -> accepted; busy_o low for exactly 1 cycle between the two operations.
